// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// A lookup is issued by pre_if with pred_req. Its registered prediction is available
// one cycle later. EXE results arriving on upd_bresult train the table.
// Optional feature macro: BPU_BYPASS_EN. When it is defined, an update to the entry being
// looked up in the same cycle is forwarded into the registered lookup result.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        BPU_valid,
    output logic        BPU_is_taken,
    output logic [31:0] BPU_ret_addr,
    output logic [1:0]  Count,
    input  logic        upd_valid,
    input  logic [67:0] upd_bresult
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    // Table storage. Only the valid bits need a reset.
    logic             v_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [31:0]      tgt_q [ENTRIES];
    logic [1:0]       cnt_q [ENTRIES];

    // Fields of the EXE result.
    logic [31:0]      u_pc;
    logic [1:0]       u_cnt;
    logic             u_br;
    logic             u_taken;
    logic [31:0]      u_target;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Lookup address split.
    logic [IDX_W-1:0] p_idx;
    logic [TAG_W-1:0] p_tag;

    // Decoded update.
    logic             upd_we;
    logic             upd_tgt_we;
    logic             new_v;
    logic [1:0]       new_cnt;

    // Entry as seen by the lookup, which may include a forwarded update.
    logic             rd_v;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_tgt;
    logic [1:0]       rd_cnt;
    logic             lk_hit;

    // Registered prediction.
    logic             bpu_valid_q;
    logic             bpu_taken_q;
    logic [31:0]      bpu_ret_q;
    logic [1:0]       bpu_cnt_q;

    // The two byte-offset bits of each PC never index the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], u_pc[1:0]};

    assign u_pc     = upd_bresult[67:36];
    assign u_cnt    = upd_bresult[35:34];
    assign u_br     = upd_bresult[33];
    assign u_taken  = upd_bresult[32];
    assign u_target = upd_bresult[31:0];
    assign u_idx    = u_pc[IDX_W+1:2];
    assign u_tag    = u_pc[31:IDX_W+2];
    assign u_hit    = v_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign p_idx = pred_pc[IDX_W+1:2];
    assign p_tag = pred_pc[31:IDX_W+2];

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    // Decode the EXE result into a table write. The counter is trained from the carried Count.
    always_comb begin
        upd_we     = 1'b0;
        upd_tgt_we = 1'b0;
        new_v      = 1'b0;
        new_cnt    = 2'b00;
        if (upd_valid) begin
            if (u_br) begin
                if (u_hit) begin
                    upd_we     = 1'b1;
                    new_v      = 1'b1;
                    new_cnt    = u_taken ? sat_inc(u_cnt) : sat_dec(u_cnt);
                    upd_tgt_we = u_taken;
                end else if (u_taken) begin
                    upd_we     = 1'b1;
                    new_v      = 1'b1;
                    new_cnt    = 2'b10;
                    upd_tgt_we = 1'b1;
                end
            end else if (u_hit) begin
                // A non-branch matched this entry, so the entry is an alias. Evict it.
                upd_we = 1'b1;
                new_v  = 1'b0;
            end
        end
    end

    // Valid bits. Reset clears them, and a reset cycle drops any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                v_q[i] <= 1'b0;
            end
        end else if (upd_we) begin
            v_q[u_idx] <= new_v;
        end
    end

    // Tag, counter and target payload. An invalidation only touches the valid bit.
    always_ff @(posedge clk) begin
        if (!reset && upd_we && new_v) begin
            tag_q[u_idx] <= u_tag;
            cnt_q[u_idx] <= new_cnt;
            if (upd_tgt_we) begin
                tgt_q[u_idx] <= u_target;
            end
        end
    end

    // Read the looked-up entry. The bypass build forwards a same-cycle update.
    always_comb begin
        rd_v   = v_q[p_idx];
        rd_tag = tag_q[p_idx];
        rd_tgt = tgt_q[p_idx];
        rd_cnt = cnt_q[p_idx];
`ifdef BPU_BYPASS_EN
        if (upd_we && (u_idx == p_idx)) begin
            rd_v = new_v;
            if (new_v) begin
                rd_tag = u_tag;
                rd_cnt = new_cnt;
                if (upd_tgt_we) begin
                    rd_tgt = u_target;
                end
            end
        end
`endif
        lk_hit = rd_v && (rd_tag == p_tag);
    end

    // Register the prediction on pred_req. Hold it otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bpu_valid_q <= 1'b0;
            bpu_taken_q <= 1'b0;
            bpu_ret_q   <= 32'h0;
            bpu_cnt_q   <= 2'b00;
        end else if (pred_req) begin
            bpu_valid_q <= lk_hit;
            bpu_taken_q <= lk_hit && rd_cnt[1];
            bpu_ret_q   <= lk_hit ? rd_tgt : 32'h0;
            bpu_cnt_q   <= lk_hit ? rd_cnt : 2'b00;
        end
    end

    assign BPU_valid    = bpu_valid_q;
    assign BPU_is_taken = bpu_taken_q;
    assign BPU_ret_addr = bpu_ret_q;
    assign Count        = bpu_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter training and saturation,
// aliasing, eviction, no-allocate on not-taken, same-cycle lookup/update, reset abort.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        BPU_valid;
    logic        BPU_is_taken;
    logic [31:0] BPU_ret_addr;
    logic [1:0]  Count;
    logic        upd_valid;
    logic [67:0] upd_bresult;

    int tests;
    int failed;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_req     (pred_req),
        .pred_pc      (pred_pc),
        .BPU_valid    (BPU_valid),
        .BPU_is_taken (BPU_is_taken),
        .BPU_ret_addr (BPU_ret_addr),
        .Count        (Count),
        .upd_valid    (upd_valid),
        .upd_bresult  (upd_bresult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic t,
                             input logic [31:0] ret, input logic [1:0] c);
        check({tag, ".valid"}, {31'h0, BPU_valid}, {31'h0, v});
        check({tag, ".taken"}, {31'h0, BPU_is_taken}, {31'h0, t});
        check({tag, ".ret"}, BPU_ret_addr, ret);
        check({tag, ".count"}, {30'h0, Count}, {30'h0, c});
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [1:0] c, input logic br,
                           input logic tk, input logic [31:0] tgt);
        upd_valid   = 1'b1;
        upd_bresult = {pc, c, br, tk, tgt};
    endtask

    // Issue one update, then one lookup in the following cycle.
    task automatic upd_then_lookup(input logic [31:0] pc, input logic [1:0] c, input logic br,
                                   input logic tk, input logic [31:0] tgt,
                                   input logic [31:0] lpc);
        pred_req = 1'b0;
        set_upd(pc, c, br, tk, tgt);
        tick();
        upd_valid = 1'b0;
        pred_req  = 1'b1;
        pred_pc   = lpc;
        tick();
        pred_req = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] lpc);
        upd_valid = 1'b0;
        pred_req  = 1'b1;
        pred_pc   = lpc;
        tick();
        pred_req = 1'b0;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        reset       = 1'b1;
        pred_req    = 1'b1;
        pred_pc     = 32'hBFC0_0010;
        upd_valid   = 1'b0;
        upd_bresult = '0;
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 32'h0, 2'b00);

        // 1: a lookup after reset misses.
        reset = 1'b0;
        tick();
        check_out("post_reset_miss", 1'b0, 1'b0, 32'h0, 2'b00);

        // 2: a taken branch allocates the entry with weakly-taken.
        upd_then_lookup(32'hBFC0_0010, 2'b00, 1'b1, 1'b1, 32'hBFC0_0100, 32'hBFC0_0010);
        check_out("alloc_hit", 1'b1, 1'b1, 32'hBFC0_0100, 2'b10);

        // The outputs hold while pred_req is low.
        pred_pc = 32'hBFC0_0110;
        tick();
        check_out("hold", 1'b1, 1'b1, 32'hBFC0_0100, 2'b10);

        // 3: counter training from the carried Count. A not-taken result keeps the target.
        upd_then_lookup(32'hBFC0_0010, 2'b10, 1'b1, 1'b0, 32'hDEAD_0000, 32'hBFC0_0010);
        check_out("dec_10", 1'b1, 1'b0, 32'hBFC0_0100, 2'b01);
        upd_then_lookup(32'hBFC0_0010, 2'b00, 1'b1, 1'b0, 32'hDEAD_0000, 32'hBFC0_0010);
        check_out("sat_00", 1'b1, 1'b0, 32'hBFC0_0100, 2'b00);
        upd_then_lookup(32'hBFC0_0010, 2'b01, 1'b1, 1'b1, 32'hBFC0_0300, 32'hBFC0_0010);
        check_out("inc_01_newtgt", 1'b1, 1'b1, 32'hBFC0_0300, 2'b10);
        upd_then_lookup(32'hBFC0_0010, 2'b11, 1'b1, 1'b1, 32'hBFC0_0100, 32'hBFC0_0010);
        check_out("sat_11", 1'b1, 1'b1, 32'hBFC0_0100, 2'b11);

        // 4: same index, different tag, misses. A non-branch hit evicts the entry.
        lookup(32'hBFC0_0110);
        check_out("alias_miss", 1'b0, 1'b0, 32'h0, 2'b00);
        upd_then_lookup(32'hBFC0_0010, 2'b11, 1'b0, 1'b0, 32'h0, 32'hBFC0_0010);
        check_out("evicted", 1'b0, 1'b0, 32'h0, 2'b00);

        // 5: not-taken branches never allocate. A non-branch miss writes nothing.
        upd_then_lookup(32'h8000_0040, 2'b00, 1'b1, 1'b0, 32'h8000_0400, 32'h8000_0040);
        check_out("nt_no_alloc", 1'b0, 1'b0, 32'h0, 2'b00);
        upd_then_lookup(32'h8000_0200, 2'b10, 1'b0, 1'b1, 32'h8000_0500, 32'h8000_0200);
        check_out("nonbr_miss", 1'b0, 1'b0, 32'h0, 2'b00);

        // 6: a lookup and an allocating update to the same index in one cycle.
        set_upd(32'h8000_0080, 2'b00, 1'b1, 1'b1, 32'h8000_1000);
        pred_req = 1'b1;
        pred_pc  = 32'h8000_0080;
        tick();
`ifdef BPU_BYPASS_EN
        check_out("same_cycle", 1'b1, 1'b1, 32'h8000_1000, 2'b10);
`else
        check_out("same_cycle", 1'b0, 1'b0, 32'h0, 2'b00);
`endif
        upd_valid = 1'b0;
        tick();
        check_out("same_cycle_next", 1'b1, 1'b1, 32'h8000_1000, 2'b10);

        // A lookup and an update to different indices proceed independently.
        set_upd(32'h8000_00C0, 2'b00, 1'b1, 1'b1, 32'h8000_2000);
        pred_req = 1'b1;
        pred_pc  = 32'h8000_0080;
        tick();
        check_out("diff_idx_lookup", 1'b1, 1'b1, 32'h8000_1000, 2'b10);
        lookup(32'h8000_00C0);
        check_out("diff_idx_upd", 1'b1, 1'b1, 32'h8000_2000, 2'b10);

        // Reset aborts a concurrent update and clears the table.
        reset = 1'b1;
        set_upd(32'h8000_0100, 2'b00, 1'b1, 1'b1, 32'h8000_3000);
        pred_req = 1'b1;
        pred_pc  = 32'h8000_0080;
        tick();
        check_out("reset_mid", 1'b0, 1'b0, 32'h0, 2'b00);
        reset = 1'b0;
        lookup(32'h8000_0100);
        check_out("reset_abort_upd", 1'b0, 1'b0, 32'h0, 2'b00);
        lookup(32'h8000_0080);
        check_out("reset_cleared", 1'b0, 1'b0, 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
